// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage unit: access FSM states and the
// byte-address to SRAM word-index translation.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } mem_state_e;

    // Byte address relative to the SRAM base, in words; the subtraction wraps modulo 2^32.
    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr,
                                                 input logic [31:0] base_addr);
        logic [31:0] offset_s;
        offset_s = byte_addr - base_addr;
        return {2'b00, offset_s[31:2]};
    endfunction

endpackage

// File: rtl/sram_access_fsm.sv
// SRAM access sequencer: owns the state, the wait counter, the single-entry
// write buffer and every SRAM pin driver.
module sram_access_fsm
    import mem_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 17,
    parameter int BASE_ADDR     = 1024,
    parameter int WAIT_CYCLES   = 5,
    parameter int POSTED_WRITES = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_req_i,
    input  logic              wr_req_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output mem_state_e        state_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              sram_w_en_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire  [DATA_W-1:0] sram_dq_io
);

    localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    mem_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wbuf_q;
    logic [DATA_W-1:0] rdata_q;
    logic              w_en_q;
    logic [ADDR_W-1:0] word_s;
    logic              last_s;

    assign word_s = ADDR_W'(byte_to_word(addr_i, 32'(BASE_ADDR)));
    assign last_s = (cnt_q == CNT_LAST);

    // Request capture, wait counting, read sampling and write-pulse generation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            wbuf_q  <= {DATA_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
            w_en_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= {CNT_W{1'b0}};
                    if (rd_req_i) begin
                        state_q <= ST_READ;
                        addr_q  <= word_s;
                    end else if (wr_req_i) begin
                        state_q <= ST_WRITE;
                        addr_q  <= word_s;
                        wbuf_q  <= wdata_i;
                        w_en_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (last_s) begin
                        rdata_q <= sram_dq_io;
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1'b1);
                    end
                end
                ST_WRITE: begin
                    if (last_s) begin
                        w_en_q  <= 1'b1;
                        cnt_q   <= {CNT_W{1'b0}};
                        // A posted drain has no stalled instruction to release.
                        state_q <= (POSTED_WRITES != 0) ? ST_IDLE : ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1'b1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= {CNT_W{1'b0}};
                    w_en_q  <= 1'b1;
                end
            endcase
        end
    end

    assign sram_dq_io  = w_en_q ? {DATA_W{1'bz}} : wbuf_q;
    assign state_o     = state_q;
    assign rdata_o     = rdata_q;
    assign sram_w_en_o = w_en_q;
    assign sram_addr_o = addr_q;

endmodule

// File: rtl/mem_unit_posted.sv
// Memory stage of the ARM pipeline: control/result pass-through, SRAM access
// through sram_access_fsm, and the stage freeze (ready) decision.
module mem_unit_posted
    import mem_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 17,
    parameter int BASE_ADDR     = 1024,
    parameter int WAIT_CYCLES   = 5,
    parameter int POSTED_WRITES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [31:0]       alu_result,
    input  logic [DATA_W-1:0] rm_val,
    input  logic [3:0]        dest_in,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [31:0]       alu_result_out,
    output logic [3:0]        dest,
    output logic [DATA_W-1:0] data_memory_out,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_w_en,
    output logic [ADDR_W-1:0] sram_address,
    output logic              ready
);

    mem_state_e state_s;
    logic       rd_req_s;
    logic       wr_req_s;
    logic       ready_s;

    // Simultaneous read and write is illegal; the read wins.
    assign rd_req_s = mem_r_en_in;
    assign wr_req_s = mem_w_en_in & ~mem_r_en_in;

    sram_access_fsm #(
        .DATA_W        (DATA_W),
        .ADDR_W        (ADDR_W),
        .BASE_ADDR     (BASE_ADDR),
        .WAIT_CYCLES   (WAIT_CYCLES),
        .POSTED_WRITES (POSTED_WRITES)
    ) u_fsm (
        .clk_i       (clk),
        .rst_ni      (rst),
        .rd_req_i    (rd_req_s),
        .wr_req_i    (wr_req_s),
        .addr_i      (alu_result),
        .wdata_i     (rm_val),
        .state_o     (state_s),
        .rdata_o     (data_memory_out),
        .sram_w_en_o (sram_w_en),
        .sram_addr_o (sram_address),
        .sram_dq_io  (sram_dq)
    );

    // Freeze decision: only memory requests stall behind a posted drain.
    always_comb begin
        ready_s = 1'b1;
        case (state_s)
            ST_IDLE: begin
                if (rd_req_s) begin
                    ready_s = 1'b0;
                end else if (wr_req_s && (POSTED_WRITES == 0)) begin
                    ready_s = 1'b0;
                end else begin
                    ready_s = 1'b1;
                end
            end
            ST_READ: begin
                ready_s = 1'b0;
            end
            ST_WRITE: begin
                if (POSTED_WRITES != 0) begin
                    ready_s = ~(rd_req_s | wr_req_s);
                end else begin
                    ready_s = 1'b0;
                end
            end
            ST_DONE: begin
                ready_s = 1'b1;
            end
            default: begin
                ready_s = 1'b1;
            end
        endcase
    end

    assign ready          = ready_s;
    assign wb_en          = wb_en_in;
    assign mem_r_en       = mem_r_en_in;
    assign mem_w_en       = mem_w_en_in;
    assign alu_result_out = alu_result;
    assign dest           = dest_in;

endmodule

// File: tb/tb_mem_unit_posted.sv
// Bench for mem_unit_posted: one posted and one non-posted instance, each with
// its own asynchronous SRAM model, checked against a timing/memory reference.
module tb_mem_unit_posted;

    localparam int WC   = 3;
    localparam int MEMW = 131072;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        wb_p, rd_p, wr_p, wb_n, rd_n, wr_n;
    logic [31:0] alu_p, rm_p, alu_n, rm_n;
    logic [3:0]  dst_p, dst_n;
    logic        wbo_p, rdo_p, wro_p, wen_p, rdy_p;
    logic        wbo_n, rdo_n, wro_n, wen_n, rdy_n;
    logic [31:0] aluo_p, dmo_p, aluo_n, dmo_n;
    logic [3:0]  dsto_p, dsto_n;
    logic [16:0] sa_p, sa_n;
    wire  [31:0] dq_p, dq_n;

    mem_unit_posted #(.DATA_W(32), .ADDR_W(17), .BASE_ADDR(1024), .WAIT_CYCLES(WC), .POSTED_WRITES(1)) dut_p (
        .clk(clk), .rst(rst), .wb_en_in(wb_p), .mem_r_en_in(rd_p), .mem_w_en_in(wr_p),
        .alu_result(alu_p), .rm_val(rm_p), .dest_in(dst_p), .wb_en(wbo_p), .mem_r_en(rdo_p),
        .mem_w_en(wro_p), .alu_result_out(aluo_p), .dest(dsto_p), .data_memory_out(dmo_p),
        .sram_dq(dq_p), .sram_w_en(wen_p), .sram_address(sa_p), .ready(rdy_p));

    mem_unit_posted #(.DATA_W(32), .ADDR_W(17), .BASE_ADDR(1024), .WAIT_CYCLES(WC), .POSTED_WRITES(0)) dut_n (
        .clk(clk), .rst(rst), .wb_en_in(wb_n), .mem_r_en_in(rd_n), .mem_w_en_in(wr_n),
        .alu_result(alu_n), .rm_val(rm_n), .dest_in(dst_n), .wb_en(wbo_n), .mem_r_en(rdo_n),
        .mem_w_en(wro_n), .alu_result_out(aluo_n), .dest(dsto_n), .data_memory_out(dmo_n),
        .sram_dq(dq_n), .sram_w_en(wen_n), .sram_address(sa_n), .ready(rdy_n));

    // Asynchronous SRAMs: output while write enable is high; a write lands only after a full WC-cycle pulse.
    logic [31:0] mem_p [0:MEMW-1];
    logic [31:0] mem_n [0:MEMW-1];
    logic        init_mem = 1'b1;
    int          low_p = 0, low_n = 0;

    assign dq_p = wen_p ? mem_p[sa_p] : 32'hzzzz_zzzz;
    assign dq_n = wen_n ? mem_n[sa_n] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 8; i++) begin
                mem_p[i] <= 32'h1000_0000 + i;
                mem_n[i] <= 32'h1000_0000 + i;
            end
            mem_p[1] <= 32'hDEAD_BEEF;        mem_n[1] <= 32'hDEAD_BEEF;
            mem_p[MEMW-1] <= 32'h0BAD_CAFE;   mem_n[MEMW-1] <= 32'h0BAD_CAFE;
            low_p <= 0;
            low_n <= 0;
        end else begin
            if (!wen_p) begin
                if (low_p + 1 == WC) mem_p[sa_p] <= dq_p;
                low_p <= low_p + 1;
            end else begin
                low_p <= 0;
            end
            if (!wen_n) begin
                if (low_n + 1 == WC) mem_n[sa_n] <= dq_n;
                low_n <= low_n + 1;
            end else begin
                low_n <= 0;
            end
        end
    end

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: per-instance SRAM contents, cycle at which the SRAM is free again, last load value.
    logic [31:0] ref_m [int];
    longint      free_at [2];
    logic [31:0] last_d [2];

    function automatic int key_of(input int s, input logic [31:0] a);
        return s * MEMW + (int'((a - 32'd1024) / 32'd4) % MEMW);
    endfunction

    function automatic void model_step(input int s, input logic rd, input logic wr, input logic [31:0] a,
                                       input logic [31:0] d, input longint t,
                                       output int stall, output logic [31:0] dexp);
        longint start;
        start = (t > free_at[s]) ? t : free_at[s];
        stall = 0;
        if (rd) begin
            stall      = int'(start - t) + WC + 1;
            free_at[s] = start + WC + 2;
            last_d[s]  = ref_m[key_of(s, a)];
        end else if (wr) begin
            ref_m[key_of(s, a)] = d;
            if (s == 1) begin
                stall      = int'(start - t);
                free_at[s] = start + 1 + WC;
            end else begin
                stall      = int'(start - t) + WC + 1;
                free_at[s] = start + WC + 2;
            end
        end
        dexp = last_d[s];
    endfunction

    task automatic idle();
        wb_p = 1'b0; rd_p = 1'b0; wr_p = 1'b0; alu_p = 32'd0; rm_p = 32'd0; dst_p = 4'd0;
        wb_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; alu_n = 32'd0; rm_n = 32'd0; dst_n = 4'd0;
    endtask

    // Presents one instruction and holds it until the stage advances; reports stall cycles.
    task automatic run_op(input int s, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int stall, output logic [31:0] dout, output logic [16:0] sa);
        idle();
        if (s == 1) begin
            wb_p = ~wr; rd_p = rd; wr_p = wr; alu_p = a; rm_p = d; dst_p = a[5:2];
        end else begin
            wb_n = ~wr; rd_n = rd; wr_n = wr; alu_n = a; rm_n = d; dst_n = a[5:2];
        end
        #1;
        if (s == 1) chk("passthru_p", 64'({wbo_p, rdo_p, wro_p, dsto_p, aluo_p}), 64'({~wr, rd, wr, a[5:2], a}));
        else        chk("passthru_n", 64'({wbo_n, rdo_n, wro_n, dsto_n, aluo_n}), 64'({~wr, rd, wr, a[5:2], a}));
        stall = 0;
        @(negedge clk);
        while (((s == 1) ? rdy_p : rdy_n) == 1'b0 && stall < 64) begin
            stall++;
            @(negedge clk);
        end
        dout = (s == 1) ? dmo_p : dmo_n;
        sa   = (s == 1) ? sa_p : sa_n;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          s;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        int          stall;
        logic [31:0] dexp;
        logic        chk_sa;
        logic [16:0] sa;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int          st, pst, lowcnt;
        logic [31:0] dout, pd, a, d;
        logic [16:0] sa;
        logic        rd, wr;
        int          op;

        tbl[0]  = '{1, 1'b1, 1'b0, 32'd1028, 32'h0,         4, 32'hDEAD_BEEF, 1'b1, 17'd1};
        tbl[1]  = '{1, 1'b0, 1'b1, 32'd1032, 32'h1234_5678, 0, 32'hDEAD_BEEF, 1'b0, 17'd0};
        tbl[2]  = '{1, 1'b1, 1'b0, 32'd1032, 32'h0,         7, 32'h1234_5678, 1'b1, 17'd2};
        tbl[3]  = '{1, 1'b0, 1'b1, 32'd1036, 32'hA0A0_A0A0, 0, 32'h1234_5678, 1'b0, 17'd0};
        tbl[4]  = '{1, 1'b0, 1'b0, 32'h55,   32'h0,         0, 32'h1234_5678, 1'b0, 17'd0};
        tbl[5]  = '{1, 1'b0, 1'b0, 32'h77,   32'h0,         0, 32'h1234_5678, 1'b0, 17'd0};
        tbl[6]  = '{1, 1'b0, 1'b1, 32'd1040, 32'hB1B1_B1B1, 1, 32'h1234_5678, 1'b0, 17'd0};
        tbl[7]  = '{1, 1'b1, 1'b1, 32'd1028, 32'h5555_5555, 7, 32'hDEAD_BEEF, 1'b1, 17'd1};
        tbl[8]  = '{1, 1'b1, 1'b0, 32'd1020, 32'h0,         4, 32'h0BAD_CAFE, 1'b1, 17'h1FFFF};
        tbl[9]  = '{0, 1'b1, 1'b0, 32'd1028, 32'h0,         4, 32'hDEAD_BEEF, 1'b1, 17'd1};
        tbl[10] = '{0, 1'b0, 1'b1, 32'd1032, 32'hCAFE_F00D, 4, 32'hDEAD_BEEF, 1'b1, 17'd2};
        tbl[11] = '{0, 1'b0, 1'b0, 32'h99,   32'h0,         0, 32'hDEAD_BEEF, 1'b0, 17'd0};
        tbl[12] = '{0, 1'b1, 1'b0, 32'd1032, 32'h0,         4, 32'hCAFE_F00D, 1'b1, 17'd2};
        tbl[13] = '{0, 1'b1, 1'b1, 32'd1028, 32'h6666_6666, 4, 32'hDEAD_BEEF, 1'b1, 17'd1};

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) ref_m[s * MEMW + i] = 32'h1000_0000 + i;
            ref_m[s * MEMW + 1]        = 32'hDEAD_BEEF;
            ref_m[s * MEMW + MEMW - 1] = 32'h0BAD_CAFE;
            free_at[s] = 0;
            last_d[s]  = 32'h0;
        end

        // Reset held: both instances at reset values.
        rst = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        init_mem = 1'b0;
        @(negedge clk);
        chk("rst_ready_p", 64'(rdy_p), 64'd1);  chk("rst_ready_n", 64'(rdy_n), 64'd1);
        chk("rst_wen_p",   64'(wen_p), 64'd1);  chk("rst_wen_n",   64'(wen_n), 64'd1);
        chk("rst_addr_p",  64'(sa_p),  64'd0);  chk("rst_addr_n",  64'(sa_n),  64'd0);
        chk("rst_dmo_p",   64'(dmo_p), 64'd0);  chk("rst_dmo_n",   64'(dmo_n), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, applied back-to-back.
        for (int i = 0; i < 14; i++) begin
            model_step(tbl[i].s, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, cyc, pst, pd);
            run_op(tbl[i].s, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, st, dout, sa);
            chk($sformatf("vec%0d_stall", i), 64'(st), 64'(tbl[i].stall));
            chk($sformatf("vec%0d_data", i), 64'(dout), 64'(tbl[i].dexp));
            if (tbl[i].chk_sa) chk($sformatf("vec%0d_addr", i), 64'(sa), 64'(tbl[i].sa));
        end

        // Posted store: no stall, write pulse of WC cycles on word 5.
        model_step(1, 1'b0, 1'b1, 32'd1044, 32'h7777_7777, cyc, pst, pd);
        run_op(1, 1'b0, 1'b1, 32'd1044, 32'h7777_7777, st, dout, sa);
        chk("pulse_stall", 64'(st), 64'd0);
        idle();
        lowcnt = 0;
        for (int k = 0; k < WC + 3; k++) begin
            @(negedge clk);
            if (!wen_p) begin
                lowcnt++;
                chk("pulse_addr", 64'(sa_p), 64'd5);
            end
        end
        chk("pulse_len", 64'(lowcnt), 64'(WC));
        chk("pulse_mem", 64'(mem_p[5]), 64'h7777_7777);
        @(posedge clk);
        #1;

        // Randomized instruction streams on each instance.
        for (int s = 1; s >= 0; s--) begin
            for (int k = 0; k < 80; k++) begin
                op = int'($urandom_range(0, 9));
                rd = (op >= 3 && op <= 5) || (op == 9);
                wr = (op >= 6);
                a  = (rd || wr) ? 32'd1024 + 32'd4 * $urandom_range(0, 7) : $urandom;
                d  = $urandom;
                model_step(s, rd, wr, a, d, cyc, pst, pd);
                run_op(s, rd, wr, a, d, st, dout, sa);
                chk($sformatf("rnd%0d_%0d_stall", s, k), 64'(st), 64'(pst));
                chk($sformatf("rnd%0d_%0d_data", s, k), 64'(dout), 64'(pd));
                if ($urandom_range(0, 4) == 0) begin
                    idle();
                    @(posedge clk);
                    #1;
                end
            end
        end
        idle();
        repeat (WC + 2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mem_p%0d", i), 64'(mem_p[i]), 64'(ref_m[MEMW + i]));
            chk($sformatf("mem_n%0d", i), 64'(mem_n[i]), 64'(ref_m[i]));
        end

        // Reset in the second WRITE cycle discards the posted write.
        run_op(1, 1'b0, 1'b1, 32'd1048, 32'hA5A5_A5A5, st, dout, sa);
        chk("rstw_stall", 64'(st), 64'd0);
        idle();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rstw_wen",   64'(wen_p), 64'd1);
        chk("rstw_ready", 64'(rdy_p), 64'd1);
        chk("rstw_addr",  64'(sa_p),  64'd0);
        chk("rstw_dmo",   64'(dmo_p), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (WC + 2) @(posedge clk);
        #1;
        chk("rstw_mem", 64'(mem_p[6]), 64'(ref_m[MEMW + 6]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_unit_posted.md
# mem_unit_posted

Parametrised memory-stage unit for the ARM pipeline. Passes writeback control and the ALU result through, and drives an external single-port asynchronous SRAM with a configurable number of wait cycles. An optional single-entry posted-write buffer lets stores retire without stalling the pipeline. `ready` is the stage's freeze signal to the hazard/pipeline-register logic.

## Interface
- `DATA_W`, 32: SRAM and register data width.
- `ADDR_W`, 17: SRAM word-address width.
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, 5: SRAM cycles per access; legal range ≥1.
- `POSTED_WRITES`, 1: 1 = stores are buffered and retire immediately; 0 = stores stall like loads.

- `clk`  in  1  clock; one clock domain, all state on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in`  in  1 each  control from the EXE/MEM register.
- `alu_result`  in  32  byte address (memory ops) or result.
- `rm_val`  in  DATA_W  store data.
- `dest_in`  in  4  destination register.
- `wb_en`, `mem_r_en`, `mem_w_en`  out  1 each  combinational pass-through.
- `alu_result_out`  out  32  pass-through.
- `dest`  out  4  pass-through.
- `data_memory_out`  out  DATA_W  last load data (registered).
- `sram_dq`  inout  DATA_W  SRAM data bus; driven only in the WRITE state.
- `sram_w_en`  out  1  SRAM write enable, active-low.
- `sram_address`  out  ADDR_W  SRAM word address (registered).
- `ready`  out  1  1 = the stage may advance this cycle.

## Operation
- Word address is `((alu_result - BASE_ADDR) >> 2)[ADDR_W-1:0]`. Example: 1024 → 0, 1028 → 1. The subtraction wraps modulo 2^32.
- FSM states: IDLE, READ, WRITE, DONE. A wait counter counts 0..WAIT_CYCLES-1.
- IDLE with no request: `ready`=1 and `sram_w_en`=1.
- IDLE with a load:
  - Latch the address; go to READ.
  - `ready`=0.
- READ:
  - Hold the address with `sram_w_en`=1 and dq at hi-Z.
  - After WAIT_CYCLES cycles, sample `sram_dq` into `data_memory_out` and go to DONE.
- DONE:
  - `ready`=1 for exactly one cycle, then IDLE.
  - The pipeline advances in this cycle, so the same request is not restarted.
- IDLE with a store when `POSTED_WRITES`=1:
  - Latch the address and `rm_val` into the buffer.
  - `ready`=1 in the same cycle; go to WRITE.
  - At the end of the last WRITE cycle, go to IDLE.
- IDLE with a store when `POSTED_WRITES`=0:
  - Go to WRITE with `ready`=0.
  - At the end of WRITE, go to DONE.
- WRITE: `sram_w_en`=0 and dq driven with buffered data for WAIT_CYCLES cycles.
- Any load or store arriving while WRITE is draining gets `ready`=0 until the drain ends. It is then accepted from IDLE on the next cycle.
- Non-memory instructions: `ready`=1 in every state except a non-posted WRITE or READ. A posted drain does not stall them.
- `mem_r_en_in` and `mem_w_en_in` both high is illegal. The read takes priority, and the write is ignored.

## Timing
- Reset values:
  - FSM IDLE, counter 0, buffer empty.
  - `sram_w_en`=1, dq hi-Z, `sram_address`=0, `data_memory_out`=0.
  - `ready` is combinational from IDLE.
- Load latency: `ready` is low in the request cycle and for WAIT_CYCLES more cycles. It is high in cycle WAIT_CYCLES+1, with `data_memory_out` valid from that cycle and held until the next load.
- Posted store: zero stall cycles. SRAM write pulse is WAIT_CYCLES cycles long.
- Non-posted store: WAIT_CYCLES+1 stall cycles, the same as a load.
- Store followed immediately by a load: the load stalls WAIT_CYCLES cycles for the drain, then takes its full load latency.
- Reset mid-operation: immediate return to reset values. `sram_w_en` deasserts asynchronously, and any pending posted write is discarded.
- `ready` is combinational from the state and the request inputs. No combinational path exists from `sram_dq`.

## Structure
- Shared package `mem_pkg`: FSM state enum and the address-translation function (BASE_ADDR, >>2).
- One sub-module, `sram_access_fsm`: state, wait counter, buffer, and SRAM pin drivers.
- The top level holds the pass-throughs and the `ready` composition.

## Test plan
- Reset held, then released: all outputs at reset values; `ready`=1; dq is Z.
- WAIT_CYCLES=3, load from 1028 with SRAM word 1 = 0xDEADBEEF: `ready` low for 4 cycles; `data_memory_out`=0xDEADBEEF in cycle 4; `sram_address`=1.
- POSTED_WRITES=1, store 0x12345678 to 1032: `ready` stays 1; `sram_w_en` low for 3 cycles on address 2; memory model holds the value.
- Store to 1032 then load from 1032 back-to-back: the load stalls 3+4 cycles and returns 0x12345678.
- POSTED_WRITES=0: a store stalls 4 cycles; an ALU op during a posted drain shows `ready`=1.
- `rst` asserted in the second WRITE cycle: `sram_w_en`=1 asynchronously; memory is unchanged after reset.
